// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the N-way round-robin arbiter.
// Latency: n/a. Backpressure: n/a.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // $clog2 returns 0 for n=1; index ports still need one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester after `last`, wrapping to index 0.
// Latency: combinational. Backpressure: none, pure function of req/last.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           valid,
    output logic [IDW-1:0] idx,
    output logic [N-1:0]   onehot
);

    logic w_hit_hi;

    // Prefer the lowest requester above `last`; otherwise wrap to the lowest overall.
    always_comb begin
        w_hit_hi = 1'b0;
        idx      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(last))) begin
                w_hit_hi = 1'b1;
                idx      = IDW'(i);
            end
        end
        if (!w_hit_hi) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    idx = IDW'(i);
                end
            end
        end
        valid = |req;
        for (int i = 0; i < N; i++) begin
            onehot[i] = valid && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter, grant held until owner eot; zero-bubble handoff.
// Latency: 1 cycle req->gnt, all outputs registered. Backpressure: owner holds until eot.
// Optional hold watchdog: RR_ARBITER_N_HOLD_TIMEOUT_EN.
module rr_arbiter_n
    import rr_arbiter_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int HOLD_MAX = 256,
    localparam int IDW      = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   eot,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic [IDW-1:0] timeout_id
);

    arb_state_e     r_state, w_state_nxt;
    logic [N-1:0]   r_gnt, w_gnt_nxt;
    logic [IDW-1:0] r_own, w_own_nxt;
    logic [IDW-1:0] r_last, w_last_nxt;

    logic           w_pick_vld;
    logic [IDW-1:0] w_pick_idx;
    logic [IDW-1:0] w_pick_last;
    logic [N-1:0]   w_pick_oh;
    logic           w_eot_own;
    logic           w_force;
    logic           w_release;
    logic           w_new_grant;

    // r_gnt is one-hot, so masking avoids a variable-width index into eot.
    assign w_eot_own   = (r_state == OWNED) && |(eot & r_gnt);
    assign w_release   = w_eot_own || w_force;
    assign w_pick_last = (r_state == OWNED) ? r_own : r_last;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .last   (w_pick_last),
        .valid  (w_pick_vld),
        .idx    (w_pick_idx),
        .onehot (w_pick_oh)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_new_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = OWNED;
                    w_gnt_nxt   = w_pick_oh;
                    w_own_nxt   = w_pick_idx;
                    w_new_grant = 1'b1;
                end
            end
            OWNED: begin
                if (w_release) begin
                    w_last_nxt = r_own;
                    if (w_pick_vld) begin
                        w_gnt_nxt   = w_pick_oh;
                        w_own_nxt   = w_pick_idx;
                        w_new_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_own_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_own_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_own   <= '0;
            r_last  <= IDW'(N - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_own;
    assign busy   = (r_state == OWNED);

`ifdef RR_ARBITER_N_HOLD_TIMEOUT_EN
    localparam int HCW = clog2_min1(HOLD_MAX);

    logic [HCW-1:0] r_hcnt;
    logic           r_timeout;
    logic [IDW-1:0] r_timeout_id;

    // A genuine eot on the limit cycle wins, so no timeout is flagged then.
    assign w_force = (r_state == OWNED) && !w_eot_own && (r_hcnt == HCW'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hcnt       <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            if (w_new_grant) begin
                r_hcnt <= '0;
            end else if (r_state == OWNED) begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            r_timeout <= w_force;
            if (w_force) begin
                r_timeout_id <= r_own;
            end
        end
    end

    assign timeout    = r_timeout;
    assign timeout_id = r_timeout_id;
`else
    assign w_force    = 1'b0;
    assign timeout    = 1'b0;
    assign timeout_id = '0;

    if (HOLD_MAX < 2) begin : g_hold_max_unsupported
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: directed scenarios plus randomized traffic vs a behavioural model.
module tb_rr_arbiter_n;

    localparam int N    = 4;
    localparam int HOLD = 8;
    localparam int IDW  = 2;
`ifdef RR_ARBITER_N_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   eot = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;
    logic [IDW-1:0] timeout_id;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter_n #(.N(N), .HOLD_MAX(HOLD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .eot        (eot),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), last served, tenure in cycles.
    int m_own  = -1;
    int m_last = N - 1;
    int m_ten  = 0;
    int m_toid = 0;
    bit m_to   = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int last);
        bit [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            t = r >> ((last + k) % N);
            if (t[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin
        bit [N-1:0] e;
        bit rel, frc;
        if (!rstn) begin
            m_own = -1; m_last = N - 1; m_ten = 0; m_to = 1'b0; m_toid = 0;
        end else begin
            m_to = 1'b0;
            if (m_own < 0) begin
                m_own = pick(req, m_last);
                m_ten = 0;
            end else begin
                e   = eot >> m_own;
                rel = e[0];
                frc = TO_EN && !rel && (m_ten == HOLD - 1);
                if (rel || frc) begin
                    if (frc) begin
                        m_to = 1'b1;
                        m_toid = m_own;
                    end
                    m_last = m_own;
                    m_own  = pick(req, m_last);
                    m_ten  = 0;
                end else begin
                    m_ten++;
                end
            end
        end
    end

    task automatic do_reset(input logic [N-1:0] r);
        rstn = 1'b0;
        req  = r;
        eot  = '0;
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = 4'b1010;
        eot  = '0;
        #1;
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b busy=%b gnt_id=%0d, want 0000/0/0", gnt, busy, gnt_id);
        end
        n_tests++;
        if (timeout !== 1'b0 || timeout_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_timeout: timeout=%b id=%0d, want 0/0", timeout, timeout_id);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b id=%0d busy=%b, want 0010/1/1", gnt, gnt_id, busy);
        end
    endtask

    task automatic test_rotation();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] want;
        do_reset(4'b1111);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            want = N'(1) << exp_seq[i];
            n_tests++;
            if (gnt !== want || gnt_id !== 2'(exp_seq[i]) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rotation[%0d]: gnt=%b id=%0d busy=%b, want %b/%0d/1", i, gnt, gnt_id, busy, want, exp_seq[i]);
            end
            eot = want;
        end
        eot = '0;
    endtask

    task automatic test_wrap();
        do_reset(4'b1000);
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_grant3: gnt=%b, want 1000", gnt);
        end
        req = 4'b0001;
        eot = 4'b0100;
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_foreign_eot: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
        end
        eot = 4'b1000;
        @(posedge clk); #1;
        eot = '0;
        n_tests++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_handoff: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_single();
        do_reset(4'b0100);
        @(posedge clk); #1;
        eot = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (gnt !== 4'b0100 || busy !== 1'b1 || gnt_id !== 2'd2) begin
                n_fail++;
                $display("FAIL single_regrant[%0d]: gnt=%b busy=%b id=%0d, want 0100/1/2", i, gnt, busy, gnt_id);
            end
        end
        req = '0;
        @(posedge clk); #1;
        eot = '0;
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL single_release_idle: gnt=%b busy=%b id=%0d, want 0000/0/0", gnt, busy, gnt_id);
        end
    endtask

    task automatic test_timeout();
        do_reset(4'b0011);
        @(posedge clk); #1;
        if (TO_EN) begin
            for (int i = 0; i < HOLD - 1; i++) begin
                @(posedge clk); #1;
                n_tests++;
                if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_hold[%0d]: gnt=%b timeout=%b, want 0001/0", i, gnt, timeout);
                end
            end
            @(posedge clk); #1;
            n_tests++;
            if (gnt !== 4'b0010 || timeout !== 1'b1 || timeout_id !== 2'd0) begin
                n_fail++;
                $display("FAIL timeout_fire0: gnt=%b timeout=%b id=%0d, want 0010/1/0", gnt, timeout, timeout_id);
            end
            for (int i = 0; i < HOLD - 1; i++) begin
                @(posedge clk); #1;
                n_tests++;
                if (gnt !== 4'b0010 || timeout !== 1'b0 || timeout_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL timeout_hold1[%0d]: gnt=%b timeout=%b id=%0d, want 0010/0/0", i, gnt, timeout, timeout_id);
                end
            end
            @(posedge clk); #1;
            n_tests++;
            if (gnt !== 4'b0001 || timeout !== 1'b1 || timeout_id !== 2'd1) begin
                n_fail++;
                $display("FAIL timeout_fire1: gnt=%b timeout=%b id=%0d, want 0001/1/1", gnt, timeout, timeout_id);
            end
        end else begin
            for (int i = 0; i < 3 * HOLD; i++) begin
                @(posedge clk); #1;
                n_tests++;
                if (gnt !== 4'b0001 || timeout !== 1'b0 || timeout_id !== 2'd0) begin
                    n_fail++;
                    $display("FAIL unbounded_hold[%0d]: gnt=%b timeout=%b id=%0d, want 0001/0/0", i, gnt, timeout, timeout_id);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        n_tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: gnt=%b busy=%b id=%0d, want 0000/0/0", gnt, busy, gnt_id);
        end
        req = 4'b1111;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] want;
        do_reset('0);
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            want = (m_own < 0) ? '0 : (N'(1) << m_own);
            n_tests++;
            if (gnt !== want || busy !== (m_own >= 0) || gnt_id !== 2'((m_own < 0) ? 0 : m_own)) begin
                n_fail++;
                $display("FAIL random_grant[%0d]: gnt=%b busy=%b id=%0d, want %b/%0b/%0d", c, gnt, busy, gnt_id, want, (m_own >= 0), (m_own < 0) ? 0 : m_own);
            end
            n_tests++;
            if (timeout !== m_to || timeout_id !== 2'(m_toid)) begin
                n_fail++;
                $display("FAIL random_timeout[%0d]: timeout=%b id=%0d, want %b/%0d", c, timeout, timeout_id, m_to, m_toid);
            end
            req = N'($urandom);
            case ($urandom_range(0, 7))
                0, 1:    eot = want | N'($urandom);
                2:       eot = ~want & N'($urandom);
                default: eot = '0;
            endcase
        end
        req = '0;
        eot = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_single();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised N-way round-robin arbiter with grant-until-end-of-transfer semantics, the successor to the fixed 4-agent arbiter. Owner handoff takes no idle cycle: when the owner asserts end-of-transfer, the next requester is granted on the following edge. An optional hold-timeout watchdog forcibly revokes a grant from an agent that never signals end-of-transfer. It sits between N bus masters and one shared resource.

## Interface
- `N`, 4: number of requesters, 1..32.
- `HOLD_MAX`, 256: maximum grant tenure in cycles (timeout build only), ≥2.
- `IDW`, `$clog2(N)` (min 1): width of the ID outputs. Derived; never overridden.

- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset, asynchronous, active-low.
- `req` input N: request per agent, level-sensitive.
- `eot` input N: end-of-transfer per agent; only the current owner's bit is honoured.
- `gnt` output N: one-hot grant, registered.
- `gnt_id` output IDW: index of the owner; 0 when `busy`=0.
- `busy` output 1: high while any grant is active.
- `timeout` output 1: one-cycle pulse on a forced release.
- `timeout_id` output IDW: index of the agent last revoked; holds its value until the next timeout.

## Operation
- State is `IDLE` or `OWNED`, plus the owner index `own`, the last-served pointer `last`, and the hold counter `hcnt`.
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `timeout_id`=0, `last`=N-1, `hcnt`=0. With `last`=N-1, agent 0 has top priority first.
- Priority order is `last+1, last+2, …` modulo N (wrap-around). The highest-priority requester with `req`=1 is selected.
- **IDLE:**
  - If any `req` is high, enter `OWNED` next edge with `own`=winner and `hcnt`=0.
  - Otherwise stay in `IDLE`.
- **OWNED:**
  - The grant is held regardless of `req`. Dropping `req` without `eot` does not release.
  - On `eot[own]`=1: set `last`=own, then select among current `req` using the updated priority.
    - If a requester exists, the grant moves to it next edge (zero bubble).
    - Otherwise go to `IDLE` with `gnt`=0.
  - If the owner asserts `eot` and `req` together and is the only requester, it is re-granted next cycle.
  - If the owner asserts `eot` and `req` together while others request, the owner loses to them.
  - Any `eot` bit other than the owner's is ignored.
- `N`=1: the single agent alternates grant/release on `eot`. Wrap-around logic degenerates cleanly.
- Reset asserted mid-grant: all outputs return asynchronously to their reset values. `last` returns to N-1.

## Timing
- Request-to-grant latency from `IDLE`: 1 cycle. `req` seen at edge k gives `gnt` high after edge k.
- Handoff: `eot` sampled at edge k means the old `gnt` drops and the new `gnt` rises, both after edge k. There is no cycle with `gnt`=0 when a requester is waiting.
- All outputs are registered. No combinational path from inputs to outputs.
- `gnt` is always one-hot or zero.
- `gnt_id` and `busy` are consistent with `gnt` every cycle.

## Configuration
- Macro: `RR_ARBITER_N_HOLD_TIMEOUT_EN`.
- **Defined:**
  - `hcnt` increments each `OWNED` cycle and resets on every new grant.
  - When `hcnt`=HOLD_MAX-1 and `eot[own]`=0, the cycle is treated as an `eot` from the owner (forced release, same handoff rules).
  - `timeout` pulses in the cycle the new `gnt` or `IDLE` appears, and `timeout_id` loads the old `own`.
  - A genuine `eot` arriving on the limit cycle takes precedence; no timeout is raised.
- **Undefined:**
  - No counter is built. `timeout` and `timeout_id` are tied to 0.
  - Tenure is unbounded.

## Structure
- Package `rr_arbiter_pkg` holds:
  - the state enum `arb_state_e` {`IDLE`, `OWNED`};
  - the helper function `clog2_min1`.
- Sub-module `rr_pick`: combinational rotating-priority picker.
  - Inputs: `req[N]`, `last`.
  - Outputs: `valid`, `idx`, `onehot`.
  - Instantiated once; reused for both the IDLE and handoff selections.

## Test plan
- Reset release with N=4, `req`=4'b1010 → `gnt`=4'b0010 one cycle later, `gnt_id`=1.
- All `req`=1111 with `eot` pulsed whenever each owner is granted → grant sequence 0,1,2,3,0, with no `gnt`=0 cycle between grants.
- Owner 3 asserts `eot` while `req`=0001 → `gnt` goes 1000 → 0001 on the next edge (wrap-around). A non-owner `eot` pulse in the same sequence changes nothing.
- Single requester 2 holds `req` and pulses `eot` → `gnt` stays 0100, re-granted every time, never idle.
- Timeout build with HOLD_MAX=8: agent 0 is granted and never asserts `eot`, agent 1 is requesting → after 8 cycles `gnt`=0010, `timeout`=1 for one cycle, `timeout_id`=0.
- Assert `rstn` low mid-grant → `gnt`=0, `busy`=0 immediately. After release with `req`=1111 → agent 0 is granted first.
